ultrasonic_proximity: RTL and testbench

Downstream consumer of the ultrasonic echo-timer. It accepts each latched echo pulse width (clock-tick count), converts it to centimetres with a serial divider, and smooths the result with a 4-sample moving average. A hysteretic classifier turns the smoothed distance into a 2-bit proximity alert that drives the helmet's haptic/buzzer logic.

---
 rtl/prox_pkg.sv | 48 ++++
 rtl/prox_divider.sv | 65 ++++++
 rtl/ultrasonic_proximity.sv | 204 ++++++++++++++++++++
 tb/tb_ultrasonic_proximity.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prox_pkg.sv
// Shared definitions for the ultrasonic proximity block: alert codes,
// FSM state encoding, moving-average window geometry and the hysteretic
// alert classifier.
package prox_pkg;

   localparam logic [1:0] ALERT_CLEAR = 2'd0;
   localparam logic [1:0] ALERT_WARN  = 2'd1;
   localparam logic [1:0] ALERT_NEAR  = 2'd2;
   localparam logic [1:0] ALERT_FAULT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DIVIDE   = 2'd1,
      ST_FILTER   = 2'd2,
      ST_CLASSIFY = 2'd3
   } prox_state_e;

   localparam int unsigned WINDOW_LEN   = 4;
   localparam int unsigned WINDOW_SHIFT = 2;
   localparam int unsigned SUM_W        = 18;

   // Hysteretic classifier; a FAULT history is treated as CLEAR so any
   // fresh sample classifies from a clean slate.
   function automatic logic [1:0] classify_alert(
      input logic [15:0] avg,
      input logic [1:0]  prev_in,
      input logic [15:0] near_lo,
      input logic [15:0] near_hi,
      input logic [15:0] far_lo,
      input logic [15:0] far_hi
   );
      logic [1:0] prev;
      logic [1:0] res;
      prev = (prev_in == ALERT_FAULT) ? ALERT_CLEAR : prev_in;
      if (avg < near_lo) begin
         res = ALERT_NEAR;
      end else if ((prev == ALERT_NEAR) && (avg < near_hi)) begin
         res = ALERT_NEAR;
      end else if ((avg < far_lo) ||
                   (((prev == ALERT_WARN) || (prev == ALERT_NEAR)) && (avg < far_hi))) begin
         res = ALERT_WARN;
      end else begin
         res = ALERT_CLEAR;
      end
      return res;
   endfunction

endpackage

// File: rtl/prox_divider.sv
// 16-bit serial restoring divider. One quotient bit per cycle; done is
// high in the cycle that performs the 16th step, so the quotient is
// valid from the following cycle. A start always restarts the divide.
module prox_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [15:0] divisor,
   output logic [15:0] quotient,
   output logic        done
);

   logic [15:0] rem_q, rem_d;
   logic [15:0] quo_q, quo_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        run_q, run_d;
   logic [16:0] rem_shift_s;

   // One shift-subtract step per cycle while running
   always_comb begin
      rem_shift_s = {rem_q, quo_q[15]};
      rem_d       = rem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      run_d       = run_q;
      if (start) begin
         rem_d = 16'd0;
         quo_d = dividend;
         cnt_d = 4'd0;
         run_d = 1'b1;
      end else if (run_q) begin
         if (rem_shift_s >= {1'b0, divisor}) begin
            rem_d = 16'(rem_shift_s - {1'b0, divisor});
            quo_d = {quo_q[14:0], 1'b1};
         end else begin
            rem_d = rem_shift_s[15:0];
            quo_d = {quo_q[14:0], 1'b0};
         end
         cnt_d = cnt_q + 4'd1;
         run_d = (cnt_q != 4'd15);
      end else begin
         run_d = 1'b0;
      end
   end

   // Divider state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q <= 16'd0;
         quo_q <= 16'd0;
         cnt_q <= 4'd0;
         run_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign done     = run_q && (cnt_q == 4'd15);
   assign quotient = quo_q;

endmodule

// File: rtl/ultrasonic_proximity.sv
// Ultrasonic proximity: echo width -> cm (serial divide) -> 4-sample
// moving average -> hysteretic 2-bit alert.
// Optional stale-data watchdog enabled by defining PROX_TIMEOUT_EN.
module ultrasonic_proximity
   import prox_pkg::*;
#(
   parameter int unsigned CYCLES_PER_CM  = 58,
   parameter int unsigned NEAR_CM        = 50,
   parameter int unsigned FAR_CM         = 150,
   parameter int unsigned HYST_CM        = 5,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pulse_in,
   input  logic        pulse_valid,
   output logic        busy,
   output logic [15:0] distance_cm,
   output logic        dist_valid,
   output logic [1:0]  alert,
   output logic        stale
);

   localparam logic [15:0] DIVISOR = 16'(CYCLES_PER_CM);
   localparam logic [15:0] NEAR_LO = 16'(NEAR_CM);
   localparam logic [15:0] NEAR_HI = 16'(NEAR_CM + HYST_CM);
   localparam logic [15:0] FAR_LO  = 16'(FAR_CM);
   localparam logic [15:0] FAR_HI  = 16'(FAR_CM + HYST_CM);

   prox_state_e state_q, state_d;

   logic        accept_s;
   logic        busy_s;
   logic        div_start_s;
   logic        div_done_s;
   logic [15:0] div_quot_s;
   logic        tmo_hit_s;

   logic [15:0] window_q [WINDOW_LEN];
   logic [15:0] window_d [WINDOW_LEN];
   logic        first_q, first_d;
   logic [15:0] distance_q, distance_d;
   logic        dist_valid_q, dist_valid_d;
   logic [1:0]  alert_q, alert_d;
   logic        stale_q, stale_d;

   logic [SUM_W-1:0] sum_s;
   logic [15:0]      avg_s;

   assign accept_s = pulse_valid && (pulse_in != 16'd0);

   prox_divider u_divider (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start_s),
      .dividend (pulse_in),
      .divisor  (DIVISOR),
      .quotient (div_quot_s),
      .done     (div_done_s)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: one pass IDLE -> DIVIDE -> FILTER -> CLASSIFY -> IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_DIVIDE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DIVIDE: begin
            if (div_done_s) begin
               state_d = ST_FILTER;
            end else begin
               state_d = ST_DIVIDE;
            end
         end
         ST_FILTER:   state_d = ST_CLASSIFY;
         ST_CLASSIFY: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: busy outside IDLE; new pulses only start the divider from IDLE
   always_comb begin
      busy_s      = (state_q != ST_IDLE);
      div_start_s = (state_q == ST_IDLE) && accept_s;
   end

   // Window sum and truncated average
   always_comb begin
      sum_s = {SUM_W{1'b0}};
      for (int i = 0; i < int'(WINDOW_LEN); i++) begin
         sum_s = sum_s + SUM_W'(window_q[i]);
      end
      avg_s = 16'(sum_s >> WINDOW_SHIFT);
   end

`ifdef PROX_TIMEOUT_EN
   logic [23:0] tmo_cnt_q, tmo_cnt_d;

   // Stale counter: restart on every accepted sample, else count and saturate
   always_comb begin
      if (div_start_s) begin
         tmo_cnt_d = 24'd0;
      end else if (tmo_cnt_q != 24'hFF_FFFF) begin
         tmo_cnt_d = tmo_cnt_q + 24'd1;
      end else begin
         tmo_cnt_d = tmo_cnt_q;
      end
   end

   // Stale counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q <= 24'd0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   assign tmo_hit_s = (tmo_cnt_q >= TIMEOUT_CYCLES);
`else
   logic unused_tmo_s;
   assign unused_tmo_s = ^TIMEOUT_CYCLES;
   assign tmo_hit_s    = 1'b0;
`endif

   // Datapath: load/shift window in FILTER, publish result in CLASSIFY,
   // force FAULT when the watchdog fires outside CLASSIFY
   always_comb begin
      window_d     = window_q;
      first_d      = first_q;
      distance_d   = distance_q;
      dist_valid_d = 1'b0;
      alert_d      = alert_q;
      stale_d      = stale_q;
      if (state_q == ST_FILTER) begin
         if (first_q) begin
            for (int i = 0; i < int'(WINDOW_LEN); i++) begin
               window_d[i] = div_quot_s;
            end
            first_d = 1'b0;
         end else begin
            window_d[0] = div_quot_s;
            for (int i = 1; i < int'(WINDOW_LEN); i++) begin
               window_d[i] = window_q[i-1];
            end
         end
      end else if (state_q == ST_CLASSIFY) begin
         distance_d   = avg_s;
         dist_valid_d = 1'b1;
         alert_d      = classify_alert(avg_s, alert_q, NEAR_LO, NEAR_HI, FAR_LO, FAR_HI);
         stale_d      = 1'b0;
      end else begin
         first_d = first_q;
      end
      if ((state_q != ST_CLASSIFY) && tmo_hit_s) begin
         stale_d = 1'b1;
         alert_d = ALERT_FAULT;
      end else begin
         stale_d = stale_d;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(WINDOW_LEN); i++) begin
            window_q[i] <= 16'd0;
         end
         first_q      <= 1'b1;
         distance_q   <= 16'd0;
         dist_valid_q <= 1'b0;
         alert_q      <= ALERT_CLEAR;
         stale_q      <= 1'b0;
      end else begin
         window_q     <= window_d;
         first_q      <= first_d;
         distance_q   <= distance_d;
         dist_valid_q <= dist_valid_d;
         alert_q      <= alert_d;
         stale_q      <= stale_d;
      end
   end

   assign busy        = busy_s;
   assign distance_cm = distance_q;
   assign dist_valid  = dist_valid_q;
   assign alert       = alert_q;
   assign stale       = stale_q;

endmodule

// File: tb/tb_ultrasonic_proximity.sv
// Self-checking bench for ultrasonic_proximity: directed scenarios plus
// randomized pulses compared with a queue-based reference model.
module tb_ultrasonic_proximity;

   localparam int unsigned CPCM = 58;
`ifdef PROX_TIMEOUT_EN
   localparam logic [23:0] TMO = 24'd1000;
`else
   localparam logic [23:0] TMO = 24'd5_000_000;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pulse_in;
   logic        pulse_valid;
   logic        busy;
   logic [15:0] distance_cm;
   logic        dist_valid;
   logic [1:0]  alert;
   logic        stale;

   always #5 clk = ~clk;

   ultrasonic_proximity #(
      .CYCLES_PER_CM  (CPCM),
      .NEAR_CM        (50),
      .FAR_CM         (150),
      .HYST_CM        (5),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pulse_in    (pulse_in),
      .pulse_valid (pulse_valid),
      .busy        (busy),
      .distance_cm (distance_cm),
      .dist_valid  (dist_valid),
      .alert       (alert),
      .stale       (stale)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int unsigned win[$];
   bit          m_first;
   int unsigned m_alert;
   int unsigned exp_dist;
   int unsigned exp_alert;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic void model_reset();
      win.delete();
      m_first  = 1'b1;
      m_alert  = 0;
      exp_dist = 0;
   endfunction

   function automatic void model_sample(input int unsigned p);
      int unsigned q, sum, avg, prev;
      q = p / CPCM;
      if (m_first) begin
         win.delete();
         repeat (4) win.push_back(q);
         m_first = 1'b0;
      end else begin
         win.push_front(q);
         void'(win.pop_back());
      end
      sum = 0;
      foreach (win[i]) sum += win[i];
      avg  = sum / 4;
      prev = (m_alert == 3) ? 0 : m_alert;
      if (avg < 50)                                             m_alert = 2;
      else if (prev == 2 && avg < 55)                           m_alert = 2;
      else if (avg < 150 || ((prev == 1 || prev == 2) && avg < 155)) m_alert = 1;
      else                                                      m_alert = 0;
      exp_dist  = avg;
      exp_alert = m_alert;
   endfunction

   // Send one nonzero pulse, follow it to dist_valid and check the result
   task automatic run_sample(input logic [15:0] p, input bit inject,
                             output int unsigned got_dist, output int unsigned got_alert);
      int k;
      logic b1, b18;
      model_sample(p);
      @(negedge clk);
      pulse_in    = p;
      pulse_valid = 1'b1;
      @(posedge clk); #1;
      pulse_valid = 1'b0;
      pulse_in    = 16'($urandom);
      k   = 1;
      b1  = busy;
      b18 = 1'b0;
      while (!dist_valid && k < 40) begin
         if (inject && k == 5) begin
            pulse_in    = 16'($urandom_range(1, 60000));
            pulse_valid = 1'b1;
         end
         @(posedge clk); #1;
         pulse_valid = 1'b0;
         k++;
         if (k == 18) b18 = busy;
      end
      check("latency", k, 19);
      check("busy_c1", b1, 1);
      check("busy_c18", b18, 1);
      check("busy_dv", busy, 0);
      check("distance", distance_cm, exp_dist);
      check("alert", alert, exp_alert);
      check("stale", stale, 0);
      got_dist  = distance_cm;
      got_alert = alert;
      @(posedge clk); #1;
      check("dv_one_cycle", dist_valid, 0);
   endtask

   task automatic quiet_window(input int cycles, input string tag);
      int dv;
      dv = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (dist_valid) dv++;
      end
      check(tag, dv, 0);
   endtask

   task automatic discard_zero();
      @(negedge clk);
      pulse_in    = 16'd0;
      pulse_valid = 1'b1;
      @(posedge clk); #1;
      pulse_valid = 1'b0;
      check("zero_not_busy", busy, 0);
      quiet_window(25, "zero_no_dv");
      check("zero_alert", alert, m_alert);
      check("zero_dist", distance_cm, exp_dist);
   endtask

   int unsigned d, a;
   int unsigned exp4_d[4] = '{85, 70, 55, 40};
   int unsigned exp4_a[4] = '{1, 1, 1, 2};

   initial begin
      reset       = 1'b1;
      pulse_in    = 16'd0;
      pulse_valid = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_dist", distance_cm, 0);
      check("rst_dv", dist_valid, 0);
      check("rst_alert", alert, 0);
      check("rst_stale", stale, 0);
      @(negedge clk);
      reset = 1'b0;

      // first sample loads the whole window; remainder is dropped
      run_sample(16'd5800, 1'b0, d, a);
      check("tp_100_d", d, 100);
      check("tp_100_a", a, 1);
      run_sample(16'd5857, 1'b0, d, a);
      check("tp_5857_d", d, 100);

      for (int i = 0; i < 4; i++) begin
         run_sample(16'd2320, 1'b0, d, a);
         check("tp_ramp_d", d, exp4_d[i]);
         check("tp_ramp_a", a, exp4_a[i]);
      end

      // NEAR hysteresis hold, then release to WARN
      repeat (6) run_sample(16'd3016, 1'b0, d, a);
      check("tp_hold_d", d, 52);
      check("tp_hold_a", a, 2);
      run_sample(16'd3596, 1'b0, d, a);
      check("tp_rel1_a", a, 2);
      run_sample(16'd3596, 1'b0, d, a);
      check("tp_rel2_a", a, 1);
      repeat (2) run_sample(16'd3596, 1'b0, d, a);

      // discarded inputs
      discard_zero();
      run_sample(16'd3596, 1'b1, d, a);
      quiet_window(25, "busy_drop_no_dv");
      run_sample(16'd4000, 1'b0, d, a);

      // reset in the middle of DIVIDE
      @(negedge clk);
      pulse_in    = 16'd1000;
      pulse_valid = 1'b1;
      @(posedge clk); #1;
      pulse_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_alert", alert, 0);
      check("mid_rst_dist", distance_cm, 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      quiet_window(20, "mid_rst_no_dv");
      run_sample(16'd9280, 1'b0, d, a);
      check("post_rst_d", d, 160);
      check("post_rst_a", a, 0);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         int unsigned sel, cm, p;
         sel = $urandom_range(0, 9);
         cm  = (sel < 3) ? $urandom_range(40, 60) :
               (sel < 6) ? $urandom_range(140, 165) : $urandom_range(0, 230);
         p   = cm * CPCM + $urandom_range(0, CPCM - 1);
         if (sel == 9 || p == 0) begin
            discard_zero();
         end else if (sel == 8) begin
            run_sample(16'(p), 1'b1, d, a);
         end else begin
            run_sample(16'(p), 1'b0, d, a);
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

`ifdef PROX_TIMEOUT_EN
      begin
         int k;
         @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         model_reset();
         k = 0;
         while (!stale && k < 1200) begin
            @(posedge clk); #1;
            k++;
         end
         check("tmo_latency", k, 1001);
         check("tmo_alert", alert, 3);
         run_sample(16'd5800, 1'b0, d, a);
         check("tmo_clear_a", a, 1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
